vga_rect_plotter: RTL and testbench

Rectangle-fill sequencer that drives the pixel-write port of `vga_adapter` (160x120, 3-bit colour). It accepts one rectangle or full-screen clear command via a valid/ready handshake and emits one registered pixel write per clock in raster order. Off-screen parts of a rectangle are clipped. It sits between command sources (switch/key logic, CPU, demo sequencers) and the adapter's `x`, `y`, `colour` and `plot` inputs.

---
 rtl/vga_rect_plotter_if.sv | 29 ++
 rtl/vga_rect_plotter.sv | 134 +++++++++++++
 tb/tb_vga_rect_plotter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_rect_plotter_if.sv
// Command and pixel-port bundle for vga_rect_plotter.
// The master side is the command source, which also observes the pixel stream.
// The slave side is the plotter.
interface vga_rect_plotter_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_clear;
   logic [7:0] cmd_x;
   logic [6:0] cmd_y;
   logic [7:0] cmd_w;
   logic [6:0] cmd_h;
   logic [2:0] cmd_colour;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       busy;
   logic       done;

   modport master (
      output cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
      input  cmd_ready, x, y, colour, plot, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
      output cmd_ready, x, y, colour, plot, busy, done
   );
endinterface

// File: rtl/vga_rect_plotter.sv
// Rectangle / full-screen fill sequencer for the 160x120 vga_adapter pixel port.
// It accepts one command in IDLE, clips it to the screen, and emits one
// registered pixel write per clock in raster order. A one-cycle done pulse
// follows the last pixel.
module vga_rect_plotter #(
   parameter int X_RES = 160,
   parameter int Y_RES = 120
) (
   input  logic               clock,
   input  logic               resetn,
   vga_rect_plotter_if.slave  bus
);

   localparam logic [8:0] XR    = 9'(X_RES);
   localparam logic [8:0] YR    = 9'(Y_RES);
   localparam logic [8:0] XR_M1 = 9'(X_RES - 1);
   localparam logic [8:0] YR_M1 = 9'(Y_RES - 1);

   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

   state_t     state;
   logic [7:0] x0;
   logic [6:0] y0;
   logic [7:0] ew_last;
   logic [6:0] eh_last;
   logic [7:0] col;
   logic [6:0] row;
   logic [2:0] colour_lat;

   logic [8:0] avail_x;
   logic [8:0] avail_y;
   logic [8:0] ew_n;
   logic [8:0] eh_n;
   logic [8:0] ew_m1;
   logic [8:0] eh_m1;
   logic       empty_n;

   function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
      return (a < b) ? a : b;
   endfunction

   assign bus.cmd_ready = (state == IDLE);

   // Clipped extents of the presented rectangle; 9-bit so nothing wraps.
   always_comb begin
      avail_x = '0;
      avail_y = '0;
      if ({1'b0, bus.cmd_x} < XR)
         avail_x = XR - {1'b0, bus.cmd_x};
      if ({2'b0, bus.cmd_y} < YR)
         avail_y = YR - {2'b0, bus.cmd_y};
      ew_n    = min9({1'b0, bus.cmd_w}, avail_x);
      eh_n    = min9({2'b0, bus.cmd_h}, avail_y);
      ew_m1   = ew_n - 9'd1;
      eh_m1   = eh_n - 9'd1;
      empty_n = (ew_n == 9'd0) || (eh_n == 9'd0);
   end

   // Control FSM with registered pixel-port outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         x0         <= '0;
         y0         <= '0;
         ew_last    <= '0;
         eh_last    <= '0;
         col        <= '0;
         row        <= '0;
         colour_lat <= '0;
         bus.x      <= '0;
         bus.y      <= '0;
         bus.colour <= '0;
         bus.plot   <= 1'b0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.plot <= 1'b0;
               bus.done <= 1'b0;
               if (bus.cmd_valid) begin
                  bus.busy   <= 1'b1;
                  colour_lat <= bus.cmd_colour;
                  col        <= '0;
                  row        <= '0;
                  if (bus.cmd_clear) begin
                     x0      <= '0;
                     y0      <= '0;
                     ew_last <= XR_M1[7:0];
                     eh_last <= YR_M1[6:0];
                     state   <= DRAW;
                  end else begin
                     x0      <= bus.cmd_x;
                     y0      <= bus.cmd_y;
                     ew_last <= ew_m1[7:0];
                     eh_last <= eh_m1[6:0];
                     state   <= empty_n ? DONE : DRAW;
                  end
               end else begin
                  // busy drops together with the done pulse.
                  bus.busy <= 1'b0;
               end
            end
            DRAW: begin
               bus.x      <= x0 + col;
               bus.y      <= y0 + row;
               bus.colour <= colour_lat;
               bus.plot   <= 1'b1;
               if (col == ew_last) begin
                  col <= '0;
                  if (row == eh_last)
                     state <= DONE;
                  else
                     row <= row + 7'd1;
               end else begin
                  col <= col + 8'd1;
               end
            end
            DONE: begin
               // done is registered here, so the FSM is already back in IDLE
               // while the pulse is visible and can take the next command.
               bus.plot <= 1'b0;
               bus.done <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               bus.plot <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_rect_plotter.sv
// Scoreboard bench for vga_rect_plotter: stimulus pushes expected pixel
// writes and done pulses (with their clock-edge numbers); a negedge monitor
// pops and compares whenever plot or done is presented.
module tb_vga_rect_plotter;

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      int         e;
   } pix_t;

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   int   edge_cnt = 0;
   int   nvec = 0;
   int   nerr = 0;
   int   plot_cnt = 0;
   pix_t exp_q[$];
   int   done_q[$];

   always #5 clock = ~clock;

   vga_rect_plotter_if bus();

   vga_rect_plotter #(.X_RES(160), .Y_RES(120)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pixel writes and done pulses against the scoreboard queues.
   always @(negedge clock) begin
      if (bus.plot) begin
         plot_cnt++;
         nvec++;
         if (exp_q.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_plot: got (%0d,%0d) c=%0d at edge %0d, expected no plot",
                     bus.x, bus.y, bus.colour, edge_cnt);
         end else begin
            pix_t e;
            e = exp_q.pop_front();
            if (bus.x !== e.x || bus.y !== e.y || bus.colour !== e.c || edge_cnt != e.e) begin
               nerr++;
               $display("FAIL pixel: got (%0d,%0d) c=%0d edge %0d, expected (%0d,%0d) c=%0d edge %0d",
                        bus.x, bus.y, bus.colour, edge_cnt, e.x, e.y, e.c, e.e);
            end
         end
      end
      if (bus.done) begin
         if (done_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_done: got done at edge %0d, expected none", edge_cnt);
         end else begin
            chk("done_edge", edge_cnt, done_q.pop_front());
         end
      end
   end

   task automatic push_rect(input int acc, input int x0, input int y0, input int w,
                            input int h, input int c, input int limit);
      int k = 0;
      for (int r = 0; r < h; r++) begin
         for (int q = 0; q < w; q++) begin
            if (limit < 0 || k < limit) begin
               pix_t p;
               p.x = 8'(x0 + q);
               p.y = 7'(y0 + r);
               p.c = 3'(c);
               p.e = acc + k + 1;
               exp_q.push_back(p);
            end
            k++;
         end
      end
      if (limit < 0)
         done_q.push_back(acc + w * h + 1);
   endtask

   task automatic send(input logic clr, input int cx, input int cy, input int cw,
                       input int ch, input int cc, output int acc);
      int n = 0;
      @(negedge clock);
      bus.cmd_valid  = 1'b1;
      bus.cmd_clear  = clr;
      bus.cmd_x      = 8'(cx);
      bus.cmd_y      = 7'(cy);
      bus.cmd_w      = 8'(cw);
      bus.cmd_h      = 7'(ch);
      bus.cmd_colour = 3'(cc);
      while (!bus.cmd_ready && n < 30000) begin
         @(negedge clock);
         n++;
      end
      if (n >= 30000) begin
         nerr++;
         $display("FAIL accept_timeout: got cmd_ready=0 for %0d cycles, expected 1", n);
         $fatal(1, "no accept");
      end
      @(posedge clock);
      #1;
      acc = edge_cnt;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || done_q.size() != 0) && n < 30000) begin
         @(negedge clock);
         n++;
      end
      if (n >= 30000) begin
         nvec++;
         nerr++;
         $display("FAIL idle_timeout: got %0d pixels and %0d dones pending, expected 0",
                  exp_q.size(), done_q.size());
         exp_q.delete();
         done_q.delete();
      end
      @(negedge clock);
      @(negedge clock);
   endtask

   initial begin
      int acc, acc2, p0;
      int empt[3][4] = '{'{5, 5, 0, 3}, '{160, 5, 3, 3}, '{5, 120, 3, 3}};

      bus.cmd_valid  = 1'b0;
      bus.cmd_clear  = 1'b0;
      bus.cmd_x      = '0;
      bus.cmd_y      = '0;
      bus.cmd_w      = '0;
      bus.cmd_h      = '0;
      bus.cmd_colour = '0;

      // Reset values while resetn is held low (valid asserted must be ignored).
      bus.cmd_valid = 1'b1;
      repeat (3) @(negedge clock);
      chk("rst_x", int'(bus.x), 0);
      chk("rst_y", int'(bus.y), 0);
      chk("rst_colour", int'(bus.colour), 0);
      chk("rst_plot", int'(bus.plot), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_ready", int'(bus.cmd_ready), 1);
      bus.cmd_valid = 1'b0;
      resetn = 1'b1;
      @(negedge clock);

      // Single-row rectangle.
      p0 = plot_cnt;
      send(1'b0, 10, 12, 5, 1, 5, acc);
      push_rect(acc, 10, 12, 5, 1, 5, -1);
      @(negedge clock);
      chk("draw_ready_low", int'(bus.cmd_ready), 0);
      chk("draw_busy_high", int'(bus.busy), 1);
      wait_idle();
      chk("row_plot_count", plot_cnt - p0, 5);
      chk("idle_busy_low", int'(bus.busy), 0);

      // Rectangle clipped at the bottom-right corner to 2x2.
      p0 = plot_cnt;
      send(1'b0, 158, 118, 4, 4, 2, acc);
      push_rect(acc, 158, 118, 2, 2, 2, -1);
      wait_idle();
      chk("clip_plot_count", plot_cnt - p0, 4);

      // Empty commands: zero width, x off-screen, y off-screen.
      for (int i = 0; i < 3; i++) begin
         p0 = plot_cnt;
         send(1'b0, empt[i][0], empt[i][1], empt[i][2], empt[i][3], 4, acc);
         push_rect(acc, 0, 0, 0, 0, 4, -1);
         while (edge_cnt < acc + 2) @(negedge clock);
         chk("empty_ready", int'(bus.cmd_ready), 1);
         wait_idle();
         chk("empty_plot_count", plot_cnt - p0, 0);
      end

      // Full-screen clear; geometry fields are ignored.
      p0 = plot_cnt;
      send(1'b1, 99, 99, 0, 0, 7, acc);
      push_rect(acc, 0, 0, 160, 120, 7, -1);
      wait_idle();
      chk("clear_plot_count", plot_cnt - p0, 19200);
      chk("clear_last_x", int'(bus.x), 159);
      chk("clear_last_y", int'(bus.y), 119);

      // Back-to-back: second command held valid during a 3x3 draw.
      send(1'b0, 40, 50, 3, 3, 1, acc);
      push_rect(acc, 40, 50, 3, 3, 1, -1);
      send(1'b0, 70, 80, 2, 1, 6, acc2);
      push_rect(acc2, 70, 80, 2, 1, 6, -1);
      chk("b2b_accept_edge", acc2 - acc, 11);
      wait_idle();

      // Asynchronous reset in the middle of a 4x4 draw, after pixel 4.
      send(1'b0, 20, 30, 4, 4, 6, acc);
      push_rect(acc, 20, 30, 4, 4, 6, 5);
      while (edge_cnt < acc + 5) @(negedge clock);
      #1;
      resetn = 1'b0;
      #1;
      chk("arst_plot", int'(bus.plot), 0);
      chk("arst_busy", int'(bus.busy), 0);
      chk("arst_done", int'(bus.done), 0);
      chk("arst_x", int'(bus.x), 0);
      chk("arst_y", int'(bus.y), 0);
      chk("arst_ready", int'(bus.cmd_ready), 1);
      chk("arst_pending", exp_q.size(), 0);
      @(posedge clock);
      @(negedge clock);
      resetn = 1'b1;
      chk("post_rst_ready", int'(bus.cmd_ready), 1);
      p0 = plot_cnt;
      send(1'b0, 0, 0, 2, 2, 3, acc);
      push_rect(acc, 0, 0, 2, 2, 3, -1);
      wait_idle();
      chk("post_rst_plot_count", plot_cnt - p0, 4);

      chk("leftover_pixels", exp_q.size(), 0);
      chk("leftover_dones", done_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
